hex_inverter_tester: RTL and testbench

Sequencer that exercises a 7404-style hex inverter, either the chip model or a physical part wired through GPIO. It drives all 64 six-bit input vectors onto the six gate inputs, waits a programmable settle time, then checks every gate output against its expected inverse. It reports busy/done, pass/fail, a saturating fail count, and the first failing vector with its per-gate mismatch mask. It sits between the lab's switch/key front end and the device under test.

---
 rtl/hex_inverter_tester.sv | 148 ++++++++++++++
 tb/tb_hex_inverter_tester.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_inverter_tester.sv
// Sequencer that sweeps all 64 six-bit vectors across a 7404-style hex
// inverter. Each vector is held for a settle time and then every gate output
// is compared against the inverse of its input. The block reports busy/done,
// pass/fail, a saturating fail count, and the first failing vector and mask.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no run in progress, results cleared, waiting for i_start
// S_SETTLE | current vector driven, counting settle cycles
// S_CHECK  | single cycle: compare i_sense against ~o_drive
// S_DONE   | run finished, results held, o_drive parked at 0
module hex_inverter_tester #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_stop_on_fail,
  output logic [5:0] o_drive,
  input  logic [5:0] i_sense,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [6:0] o_fail_count,
  output logic [5:0] o_first_fail_vec,
  output logic [5:0] o_first_fail_mask
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [6:0] FAIL_MAX = 7'd64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       vec_q, vec_d;
  logic [5:0]       drive_q, drive_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       fail_q, fail_d;
  logic [5:0]       ffvec_q, ffvec_d;
  logic [5:0]       ffmask_q, ffmask_d;
  logic [5:0]       mismatch;

  // A healthy gate drives the inverse of its input, so any output bit that
  // equals its drive bit is a faulty gate.
  assign mismatch = ~(i_sense ^ drive_q);

  // State and result registers; reset returns everything to zero at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      drive_q  <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      ffvec_q  <= '0;
      ffmask_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      drive_q  <= drive_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      ffvec_q  <= ffvec_d;
      ffmask_q <= ffmask_d;
    end
  end

  // Next-state and result update; abort overrides everything else.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    drive_d  = drive_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    ffvec_d  = ffvec_q;
    ffmask_d = ffmask_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d  = S_SETTLE;
          vec_d    = '0;
          drive_d  = '0;
          cnt_d    = '0;
          fail_d   = '0;
          ffvec_d  = '0;
          ffmask_d = '0;
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (mismatch != 6'd0) begin
          if (fail_q != FAIL_MAX) begin
            fail_d = fail_q + 7'd1;
          end
          if (fail_q == 7'd0) begin
            ffvec_d  = vec_q;
            ffmask_d = mismatch;
          end
        end
        if ((vec_q == 6'd63) || ((mismatch != 6'd0) && i_stop_on_fail)) begin
          state_d = S_DONE;
          drive_d = '0;
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 6'd1;
          drive_d = vec_q + 6'd1;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (i_abort) begin
      state_d  = S_IDLE;
      vec_d    = '0;
      drive_d  = '0;
      cnt_d    = '0;
      fail_d   = '0;
      ffvec_d  = '0;
      ffmask_d = '0;
    end
  end

  assign o_drive           = drive_q;
  assign o_busy            = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign o_done            = (state_q == S_DONE);
  assign o_pass            = (state_q == S_DONE) && (fail_q == 7'd0);
  assign o_fail_count      = fail_q;
  assign o_first_fail_vec  = ffvec_q;
  assign o_first_fail_mask = ffmask_q;

endmodule

// File: tb/tb_hex_inverter_tester.sv
// Bench for hex_inverter_tester: a configurable inverter model (stuck-at and
// buffer faults per gate) sits on o_drive/i_sense, and a per-vector sweep
// model predicts counts, first failure and run length.
module tb_hex_inverter_tester;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stop_on_fail = 1'b0;
  logic [5:0] drive, sense;
  logic [5:0] st1 = '0, st0 = '0, bm = '0;
  logic       busy, done, pass;
  logic [6:0] fcnt;
  logic [5:0] ffv, ffm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Chip model: stuck-at-0 wins over stuck-at-1, buffer gates pass input through.
  assign sense = ((~drive & ~bm) | (drive & bm) | st1) & ~st0;

  hex_inverter_tester #(.SETTLE_CYCLES(S)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_abort          (abort),
    .i_stop_on_fail   (stop_on_fail),
    .o_drive          (drive),
    .i_sense          (sense),
    .o_busy           (busy),
    .o_done           (done),
    .o_pass           (pass),
    .o_fail_count     (fcnt),
    .o_first_fail_vec (ffv),
    .o_first_fail_mask(ffm)
  );

  // Sweep model: walk vectors gate by gate and decide what a tester must report.
  task automatic model_run(input logic stop, output int cnt, output logic [5:0] fv,
                           output logic [5:0] fm, output int endv);
    cnt = 0; fv = '0; fm = '0; endv = 63;
    for (int v = 0; v < 64; v++) begin
      logic [5:0] m;
      m = '0;
      for (int g = 0; g < 6; g++) begin
        int d, o;
        d = (v >> g) & 1;
        if (st0[g]) o = 0;
        else if (st1[g]) o = 1;
        else if (bm[g]) o = d;
        else o = 1 - d;
        if (o == d) m[g] = 1'b1;
      end
      if (m != 0) begin
        if (cnt == 0) begin fv = 6'(v); fm = m; end
        if (cnt < 64) cnt++;
        if (stop) begin endv = v; break; end
      end
    end
  endtask

  // Starts a run and follows it to DONE, comparing against the sweep model.
  // hold keeps i_start high for the whole run (and leaves it high afterwards).
  task automatic do_run(input logic stop, input bit poke, input bit hold);
    int ecnt, endv, k, busy_n, drive_bad, exp_k;
    logic [5:0] efv, efm;
    model_run(stop, ecnt, efv, efm, endv);
    exp_k = (endv + 1) * (S + 1) + 1;
    @(posedge clk); #1;
    start = 1'b1; stop_on_fail = stop;
    k = 0; busy_n = 0; drive_bad = 0;
    while (!done || k == 0) begin
      @(posedge clk); #1;
      k++;
      if (!hold) start = poke && (k % 7 == 3);
      if (busy) begin
        busy_n++;
        if (drive !== 6'((k - 1) / (S + 1))) drive_bad++;
      end
      if (k > 2000) break;
    end
    if (!hold) start = 1'b0;
    checks++;
    if (k !== exp_k) begin errors++; $display("FAIL run_length: got %0d want %0d", k, exp_k); end
    checks++;
    if (busy_n !== exp_k - 1) begin errors++; $display("FAIL busy_cycles: got %0d want %0d", busy_n, exp_k - 1); end
    checks++;
    if (drive_bad !== 0) begin errors++; $display("FAIL drive_sequence: got %0d bad cycles want 0", drive_bad); end
    checks++;
    if (fcnt !== 7'(ecnt)) begin errors++; $display("FAIL fail_count: got %0d want %0d", fcnt, ecnt); end
    checks++;
    if (ffv !== efv || ffm !== efm) begin
      errors++; $display("FAIL first_fail: got vec=%h mask=%b want vec=%h mask=%b", ffv, ffm, efv, efm);
    end
    checks++;
    if (pass !== (ecnt == 0) || drive !== 6'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_outputs: got pass=%b drive=%h busy=%b want pass=%b drive=0 busy=0",
                         pass, drive, busy, ecnt == 0);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, pass, fcnt, ffv, ffm, drive} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {busy, done, pass, fcnt, ffv, ffm, drive});
    end
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, pass, fcnt, ffv, ffm, drive} !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %h want 0", {busy, done, pass, fcnt, ffv, ffm, drive});
    end
  endtask

  task automatic test_good_run();
    st1 = '0; st0 = '0; bm = '0;
    do_run(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_gate3();
    st1 = 6'b001000; st0 = '0; bm = '0;
    do_run(1'b0, 1'b0, 1'b0);
    checks++;
    if (fcnt !== 7'd32 || ffv !== 6'h08 || ffm !== 6'b001000) begin
      errors++; $display("FAIL stuck3_literal: got cnt=%0d vec=%h mask=%b want 32 08 001000", fcnt, ffv, ffm);
    end
    do_run(1'b1, 1'b0, 1'b0);
    checks++;
    if (fcnt !== 7'd1) begin errors++; $display("FAIL stuck3_stop_count: got %0d want 1", fcnt); end
  endtask

  task automatic test_buffers();
    st1 = '0; st0 = '0; bm = 6'b100001;
    do_run(1'b0, 1'b0, 1'b0);
    checks++;
    if (fcnt !== 7'd64 || ffv !== 6'h00 || ffm !== 6'b100001) begin
      errors++; $display("FAIL buffer_saturate: got cnt=%0d vec=%h mask=%b want 64 00 100001", fcnt, ffv, ffm);
    end
  endtask

  task automatic test_abort();
    st1 = 6'b001000; st0 = '0; bm = '0;
    @(posedge clk); #1;
    start = 1'b1; stop_on_fail = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20 * (S + 1) + 2) @(posedge clk);
    #1;
    checks++;
    if (drive !== 6'd20 || fcnt !== 7'd8) begin
      errors++; $display("FAIL abort_precondition: got drive=%0d cnt=%0d want 20 8", drive, fcnt);
    end
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, pass, fcnt, ffv, ffm, drive} !== '0) begin
      errors++; $display("FAIL abort_clears: got %h want 0", {busy, done, pass, fcnt, ffv, ffm, drive});
    end
    st1 = '0;
    do_run(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    st1 = 6'b001000; st0 = '0; bm = '0;
    @(posedge clk); #1;
    start = 1'b1; stop_on_fail = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12 * (S + 1) + 1) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, fcnt, ffv, ffm, drive} !== '0) begin
      errors++; $display("FAIL async_reset: got %h want 0", {busy, done, pass, fcnt, ffv, ffm, drive});
    end
    #2 rst_n = 1'b1;
    st1 = '0;
  endtask

  task automatic test_busy_start_ignored();
    st1 = '0; st0 = 6'b000100; bm = '0;
    do_run(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_held_start_restart();
    st1 = 6'b000010; st0 = '0; bm = '0;
    do_run(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || fcnt !== 7'd0 || ffv !== 6'd0 || ffm !== 6'd0 || drive !== 6'd0) begin
      errors++; $display("FAIL held_restart: got busy=%b done=%b cnt=%0d vec=%h mask=%b drive=%h want 1 0 0 0 0 0",
                         busy, done, fcnt, ffv, ffm, drive);
    end
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      st1 = 6'($urandom) & 6'($urandom) & 6'($urandom);
      st0 = 6'($urandom) & 6'($urandom) & 6'($urandom);
      bm  = 6'($urandom) & 6'($urandom);
      do_run(1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_stuck_gate3();
    test_buffers();
    test_abort();
    test_reset_mid_run();
    test_busy_start_ignored();
    test_held_start_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
